// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues requests to instruction memory and feeds the F/D pipeline register.
// Defining FETCH_ADEL_EN adds fetch address checking (misaligned or out-of-window PC raises d_exc).
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] f_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic        d_valid,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic        d_exc
);

   typedef enum logic {
      ST_REQ,
      ST_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fPc_q, fPc_d;
   logic [31:0] buf_q, buf_d;
   logic        dValid_q, dValid_d;
   logic [31:0] dInstr_q, dInstr_d;
   logic [31:0] dPc_q, dPc_d;
   logic        dExc_q, dExc_d;

   logic        addrBad;
   logic        avail;
   logic [31:0] instr;

`ifdef FETCH_ADEL_EN
   // A bad address never reaches memory; it completes at once as a zero word flagged as an exception.
   assign addrBad = (fPc_q[1:0] != 2'b00) || (fPc_q < 32'h0000_3000) || (fPc_q > 32'h0000_6FFF);
`else
   assign addrBad = 1'b0;
`endif

   assign f_pc    = fPc_q;
   assign im_addr = fPc_q;
   assign im_req  = (state_q == ST_REQ) && !addrBad;
   assign d_valid = dValid_q;
   assign d_instr = dInstr_q;
   assign d_pc    = dPc_q;
   assign d_exc   = dExc_q;

   always_comb begin
      avail = 1'b1;
      instr = buf_q;
      if (state_q == ST_REQ) begin
         avail = addrBad || im_ack;
         instr = addrBad ? 32'h0 : im_rdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      fPc_d    = fPc_q;
      buf_d    = buf_q;
      dValid_d = dValid_q;
      dInstr_d = dInstr_q;
      dPc_d    = dPc_q;
      dExc_d   = dExc_q;
      if (flush) begin
         dValid_d = 1'b0;
         dInstr_d = 32'h0;
         dExc_d   = 1'b0;
         buf_d    = 32'h0;
         fPc_d    = npc;
         state_d  = ST_REQ;
      end else if (avail && !stall) begin
         dValid_d = 1'b1;
         dInstr_d = instr;
         dPc_d    = fPc_q;
         dExc_d   = addrBad;
         fPc_d    = npc;
         state_d  = ST_REQ;
      end else if (avail) begin
         // D cannot accept: park the word so the request can be released without a refetch.
         buf_d   = instr;
         state_d = ST_HOLD;
      end else if (!stall) begin
         dValid_d = 1'b0;
         dInstr_d = 32'h0;
         dExc_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_REQ;
         fPc_q    <= 32'h0000_3000;
         buf_q    <= 32'h0;
         dValid_q <= 1'b0;
         dInstr_q <= 32'h0;
         dPc_q    <= 32'h0000_3000;
         dExc_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fPc_q    <= fPc_d;
         buf_q    <= buf_d;
         dValid_q <= dValid_d;
         dInstr_q <= dInstr_d;
         dPc_q    <= dPc_d;
         dExc_q   <= dExc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] npc;
   logic        stall;
   logic        flush;
   logic [31:0] f_pc;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic        d_valid;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic        d_exc;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: current PC, an optional parked instruction, and the expected F/D contents.
   logic [31:0] mPc;
   bit          mHeld;
   logic [31:0] mHeldWord;
   bit          mDValid;
   logic [31:0] mDInstr;
   logic [31:0] mDPc;
   bit          mDExc;

   fetch_unit dut (
      .clk      (clk),
      .reset    (reset),
      .npc      (npc),
      .stall    (stall),
      .flush    (flush),
      .f_pc     (f_pc),
      .im_req   (im_req),
      .im_addr  (im_addr),
      .im_ack   (im_ack),
      .im_rdata (im_rdata),
      .d_valid  (d_valid),
      .d_instr  (d_instr),
      .d_pc     (d_pc),
      .d_exc    (d_exc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic bit addrBad(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
      return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6FFF);
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPc       = 32'h3000;
      mHeld     = 1'b0;
      mHeldWord = 32'h0;
      mDValid   = 1'b0;
      mDInstr   = 32'h0;
      mDPc      = 32'h3000;
      mDExc     = 1'b0;
   endtask

   // Drive one cycle of inputs, compare every output against the model, then advance the model at the edge.
   task automatic applyStimulus(input bit r, input bit s, input bit f, input bit a, input logic [31:0] n);
      bit          expReq;
      bit          bad;
      bit          avail;
      logic [31:0] word;
      @(negedge clk);
      reset    = r;
      stall    = s;
      flush    = f;
      im_ack   = a;
      npc      = n;
      im_rdata = a ? memWord(mPc) : 32'hDEAD_BEEF;
      #1;
      bad    = addrBad(mPc);
      expReq = !mHeld && !bad;
      checkOutput("f_pc", f_pc, mPc);
      checkOutput("im_req", {31'b0, im_req}, {31'b0, expReq});
      if (expReq) checkOutput("im_addr", im_addr, mPc);
      checkOutput("d_valid", {31'b0, d_valid}, {31'b0, mDValid});
      checkOutput("d_instr", d_instr, mDInstr);
      checkOutput("d_pc", d_pc, mDPc);
      checkOutput("d_exc", {31'b0, d_exc}, {31'b0, mDExc});
      @(posedge clk);
      avail = mHeld || bad || a;
      word  = mHeld ? mHeldWord : (bad ? 32'h0 : memWord(mPc));
      if (r) begin
         modelReset();
      end else if (f) begin
         mDValid = 1'b0; mDInstr = 32'h0; mDExc = 1'b0;
         mPc = n; mHeld = 1'b0;
      end else if (avail && !s) begin
         mDValid = 1'b1; mDInstr = word; mDPc = mPc; mDExc = bad;
         mPc = n; mHeld = 1'b0;
      end else if (avail) begin
         mHeld = 1'b1; mHeldWord = word;
      end else if (!s) begin
         mDValid = 1'b0; mDInstr = 32'h0; mDExc = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] n;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; im_ack = 1'b0;
      npc = 32'h0; im_rdata = 32'h0;
      repeat (2) @(posedge clk);
      modelReset();

      // Back-to-back fetches with im_ack held high.
      applyStimulus(0, 0, 0, 1, mPc + 4);
      #1 checkOutput("seq_pc0", d_pc, 32'h3000);
      checkOutput("seq_valid0", {31'b0, d_valid}, 32'h1);
      applyStimulus(0, 0, 0, 1, mPc + 4);
      #1 checkOutput("seq_pc1", d_pc, 32'h3004);
      applyStimulus(0, 0, 0, 1, mPc + 4);
      #1 checkOutput("seq_pc2", d_pc, 32'h3008);

      // Stall with the word arriving: request drops, F/D holds, release delivers the parked word.
      applyStimulus(0, 1, 0, 1, mPc + 4);
      #1 checkOutput("stall_req", {31'b0, im_req}, 32'h0);
      checkOutput("stall_hold_pc", d_pc, 32'h3008);
      applyStimulus(0, 1, 0, 1, mPc + 4);
      #1 checkOutput("stall_fpc", f_pc, 32'h300C);
      applyStimulus(0, 0, 0, 0, mPc + 4);
      #1 checkOutput("release_pc", d_pc, 32'h300C);
      checkOutput("release_instr", d_instr, memWord(32'h300C));

      // Flush beats stall and redirects.
      applyStimulus(0, 1, 1, 1, 32'h3400);
      #1 checkOutput("flush_valid", {31'b0, d_valid}, 32'h0);
      checkOutput("flush_addr", im_addr, 32'h3400);

      // Slow memory: three waiting cycles produce bubbles, then the word lands.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, mPc + 4);
         #1 checkOutput("wait_req", {31'b0, im_req}, 32'h1);
         checkOutput("wait_bubble", {31'b0, d_valid}, 32'h0);
      end
      applyStimulus(0, 0, 0, 1, 32'h3002);
      #1 checkOutput("late_instr", d_instr, memWord(32'h3400));
      checkOutput("late_pc", d_pc, 32'h3400);

      // Misaligned redirect target.
      applyStimulus(0, 0, 0, 1, 32'h3010);
`ifdef FETCH_ADEL_EN
      #1 checkOutput("adel_exc", {31'b0, d_exc}, 32'h1);
      checkOutput("adel_instr", d_instr, 32'h0);
`else
      #1 checkOutput("noadel_exc", {31'b0, d_exc}, 32'h0);
      checkOutput("noadel_instr", d_instr, memWord(32'h3002));
`endif
      checkOutput("misalign_pc", d_pc, 32'h3002);

      // Reset while a request is waiting; the late ack must be dropped.
      applyStimulus(0, 0, 0, 0, mPc + 4);
      applyStimulus(1, 1, 1, 1, 32'h5000);
      #1 checkOutput("rst_fpc", f_pc, 32'h3000);
      checkOutput("rst_valid", {31'b0, d_valid}, 32'h0);
      checkOutput("rst_addr", im_addr, 32'h3000);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0:       n = {$urandom} & 32'hFFFF_FFFC;
            1:       n = $urandom;
            2, 3:    n = $urandom_range(32'h3000, 32'h6FFF) & 32'hFFFF_FFFC;
            default: n = mPc + 4;
         endcase
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
